// File: rtl/read_byte_ctrl.sv
// Byte-fetch sequencer for the CABAC arithmetic decoder: owns bitsNeeded and
// pulls upstream bytes into the accumulate datapath on renormalization.
module read_byte_ctrl #(
  parameter int              INIT_BYTES = 2,
  parameter logic signed [3:0] BN_INIT  = -4'sd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       upd_valid,
  input  logic       upd_bypass,
  input  logic [2:0] upd_shift,
  output logic       upd_ready,
  output logic [3:0] bits_needed,
  output logic [3:0] shift_amt,
  output logic [7:0] byte_out,
  output logic       load_flag,
  output logic       sel_order_sum,
  output logic       init_load,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, WAIT_BYTE} state_t;

  state_t     state;
  logic [1:0] init_cnt;
  logic [3:0] bn_q;
  logic [3:0] bn_lat;
  logic       byp_lat;
  logic [4:0] bn_sum;
  logic       upd_acc;
  logic       run_load;
  logic       wait_load;
  logic       init_take;
  logic       load_byp;

  // Sign-extended 5-bit sum; bit 4 set means bn_next is still negative.
  assign bn_sum = {bn_q[3], bn_q} + (upd_bypass ? 5'd1 : {2'b00, upd_shift});

  assign upd_ready = (state == RUN) && !start;
  assign upd_acc   = upd_ready && upd_valid;
  assign run_load  = upd_acc && !bn_sum[4] && byte_valid;
  assign wait_load = (state == WAIT_BYTE) && !start && byte_valid;
  assign init_take = (state == INIT) && !start && byte_valid;

  assign load_flag  = run_load || wait_load;
  assign init_load  = init_take;
  assign byte_ready = load_flag || init_take;
  assign byte_out   = byte_ready ? byte_in : 8'h00;
  assign shift_amt  = run_load ? bn_sum[3:0] : (wait_load ? bn_lat : 4'h0);
  assign load_byp   = run_load ? upd_bypass : byp_lat;
  assign busy       = (state == INIT) || (state == WAIT_BYTE);
  assign bits_needed = bn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      init_cnt      <= 2'd0;
      bn_q          <= BN_INIT;
      bn_lat        <= 4'h0;
      byp_lat       <= 1'b0;
      sel_order_sum <= 1'b1;
    end else if (start) begin
      // Restart drops any pending byte and the update that caused it.
      state         <= INIT;
      init_cnt      <= 2'd0;
      sel_order_sum <= 1'b1;
    end else begin
      case (state)
        INIT: if (init_take) begin
          init_cnt <= init_cnt + 2'd1;
          if (init_cnt == 2'(INIT_BYTES - 1)) begin
            state         <= RUN;
            bn_q          <= BN_INIT;
            sel_order_sum <= 1'b1;
          end
        end
        RUN: if (upd_acc) begin
          if (bn_sum[4]) begin
            bn_q <= bn_sum[3:0];
          end else if (byte_valid) begin
            bn_q <= bn_sum[3:0] - 4'd8;
            if (load_byp) sel_order_sum <= ~sel_order_sum;
          end else begin
            bn_lat  <= bn_sum[3:0];
            byp_lat <= upd_bypass;
            state   <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: if (wait_load) begin
          bn_q  <= bn_lat - 4'd8;
          if (load_byp) sel_order_sum <= ~sel_order_sum;
          state <= RUN;
        end
        default: ;
      endcase
    end
  end

endmodule
